aes_inv_key_sched: RTL and testbench

Iterative AES-128 decryption key scheduler. It loads a 128-bit cipher key, expands it forward one round per cycle to round key 10, then streams round keys 10 down to 0 over a valid/ready handshake. Keys are regenerated backward on the fly with the inverse key-schedule recurrence, so no 11-entry key store is needed. It feeds the decryption round datapath and is the counterpart of the combinational encryption key expansion.

---
 rtl/aes_inv_key_sched.sv | 128 ++++++++++++
 tb/tb_aes_inv_key_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key scheduler: expands the cipher key forward to round 10,
// then streams round keys 10..0, regenerating each earlier key from the current
// one with the inverse key-schedule recurrence instead of storing all eleven.
module aes_inv_key_sched (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk,
   output logic [3:0]   rk_round,
   output logic         rk_last
);

   typedef enum logic [1:0] {IDLE, EXPAND, EMIT} stateT;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] invXtime(input logic [7:0] x);
      return x[0] ? ((x >> 1) ^ 8'h8d) : (x >> 1);
   endfunction

   stateT        state;
   logic [127:0] keyReg;
   logic [7:0]   rcon;
   logic [3:0]   round;
   logic         rkValid;

   logic [31:0] a0, a1, a2, a3;
   logic [31:0] gIn, gRot, gOut;
   logic [31:0] n0, n1, n2, n3;
   logic [31:0] p0, p1, p2, p3;

   assign a0 = keyReg[127:96];
   assign a1 = keyReg[95:64];
   assign a2 = keyReg[63:32];
   assign a3 = keyReg[31:0];

   // One shared g() path: forward steps feed a3, backward steps feed the recovered a3 (a3 ^ a2).
   always_comb begin
      gIn  = (state == EMIT) ? (a3 ^ a2) : a3;
      gRot = {gIn[23:0], gIn[31:24]};
      gOut = {sbox(gRot[31:24]), sbox(gRot[23:16]), sbox(gRot[15:8]), sbox(gRot[7:0])}
             ^ {rcon, 24'h000000};
      n0 = a0 ^ gOut;
      n1 = a1 ^ n0;
      n2 = a2 ^ n1;
      n3 = a3 ^ n2;
      p3 = a3 ^ a2;
      p2 = a2 ^ a1;
      p1 = a1 ^ a0;
      p0 = a0 ^ gOut;
   end

   // Control and datapath: load, expand to round 10, then walk back one key per handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         keyReg  <= '0;
         rcon    <= 8'h00;
         round   <= 4'd0;
         rkValid <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  keyReg <= key;
                  round  <= 4'd0;
                  rcon   <= 8'h01;
                  busy   <= 1'b1;
                  state  <= EXPAND;
               end
            end
            EXPAND: begin
               keyReg <= {n0, n1, n2, n3};
               round  <= round + 4'd1;
               if (round == 4'd9) begin
                  state   <= EMIT;
                  rkValid <= 1'b1;
               end else begin
                  rcon <= xtime(rcon);
               end
            end
            EMIT: begin
               if (rk_ready) begin
                  if (round != 4'd0) begin
                     keyReg <= {p0, p1, p2, p3};
                     round  <= round - 4'd1;
                     rcon   <= invXtime(rcon);
                  end else begin
                     state   <= IDLE;
                     rkValid <= 1'b0;
                     busy    <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rk       = keyReg;
   assign rk_round = round;
   assign rk_valid = rkValid;
   assign rk_last  = rkValid && (round == 4'd0);

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched: a forward key-expansion model
// (S-box derived from GF(2^8) inverses) fills a scoreboard queue of expected
// round keys, which are popped as the DUT hands them over.
module tb_aes_inv_key_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [127:0] key;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk;
   logic [3:0]   rk_round;
   logic         rk_last;

   typedef struct packed {
      logic [3:0]   round;
      logic [127:0] rkey;
   } expT;

   expT          expQ[$];
   logic [7:0]   sboxM [256];
   logic [127:0] got [11];
   logic [127:0] gotRef [11];
   int           checks = 0;
   int           failures = 0;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   always #5 clk = ~clk;

   aes_inv_key_sched dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key(key), .busy(busy),
      .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_round(rk_round),
      .rk_last(rk_last)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   // S-box built from its definition: multiplicative inverse followed by the affine map.
   task automatic buildSbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
         sboxM[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // Full forward expansion into 44 words, then push keys 10 down to 0 as expectations.
   task automatic expandPush(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      expT         e;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sboxM[t[31:24]], sboxM[t[23:16]], sboxM[t[15:8]], sboxM[t[7:0]]} ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 10; r >= 0; r--) begin
         e.round = 4'(r);
         e.rkey  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         expQ.push_back(e);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Raise start for one cycle at the current negedge; returns at the negedge after the sampling edge.
   task automatic applyStimulus(input logic [127:0] k);
      start = 1'b1;
      key   = k;
      expandPush(k);
      @(negedge clk);
      start = 1'b0;
      key   = ~k;
      checkOutput("busy_after_start", 128'(busy), 128'(1));
   endtask

   // Drain one schedule against the scoreboard, optionally with backpressure, stray starts or an abort.
   task automatic runSchedule(input bit randomReady, input int injectA, input int injectB,
                              input logic [127:0] injectKey, input int abortRound,
                              input bit checkLatency);
      int           cyc, popped, firstValid;
      bit           stalled, busyDrop, aborted;
      logic [127:0] holdRk;
      logic [3:0]   holdRound;
      expT          e;
      cyc = 0; popped = 0; firstValid = -1;
      stalled = 1'b0; busyDrop = 1'b0; aborted = 1'b0;
      holdRk = '0; holdRound = '0;
      while (popped < 11 && cyc < 300 && !aborted) begin
         @(negedge clk);
         cyc++;
         start = (cyc == injectA || cyc == injectB);
         if (start) key = injectKey;
         if (stalled) begin
            checkOutput("stall_rk", rk, holdRk);
            checkOutput("stall_round", 128'(rk_round), 128'(holdRound));
            checkOutput("stall_valid", 128'(rk_valid), 128'(1));
         end
         if (!busy) busyDrop = 1'b1;
         if (rk_valid && firstValid < 0) firstValid = cyc;
         if (abortRound >= 0 && rk_valid && rk_round == 4'(abortRound)) begin
            rst_n = 1'b0;
            #1;
            checkOutput("abort_busy", 128'(busy), 128'(0));
            checkOutput("abort_valid", 128'(rk_valid), 128'(0));
            checkOutput("abort_rk", rk, 128'(0));
            checkOutput("abort_round", 128'(rk_round), 128'(0));
            checkOutput("abort_last", 128'(rk_last), 128'(0));
            expQ.delete();
            aborted = 1'b1;
         end else begin
            rk_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_valid && rk_ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_key", 128'(1), 128'(0));
               end else begin
                  e = expQ.pop_front();
                  checkOutput("rk", rk, e.rkey);
                  checkOutput("rk_round", 128'(rk_round), 128'(e.round));
                  checkOutput("rk_last", 128'(rk_last), 128'(e.round == 4'd0));
               end
               got[rk_round] = rk;
               popped++;
            end
            stalled   = rk_valid && !rk_ready;
            holdRk    = rk;
            holdRound = rk_round;
         end
      end
      start = 1'b0;
      checkOutput("schedule_complete", 128'(popped == 11 || aborted), 128'(1));
      if (!aborted) begin
         if (checkLatency) checkOutput("latency", 128'(firstValid), 128'(10));
         checkOutput("busy_held", 128'(busyDrop), 128'(0));
         @(negedge clk);
         checkOutput("done_valid", 128'(rk_valid), 128'(0));
         checkOutput("done_busy", 128'(busy), 128'(0));
         checkOutput("done_rk_hold", rk, got[0]);
      end
   endtask

   // Directed sequence: reset, FIPS run, back-to-back runs, backpressure, stray starts, abort.
   initial begin
      bit sawValid;
      logic [127:0] randKey;
      rst_n = 1'b0; start = 1'b0; key = '0; rk_ready = 1'b1;
      buildSbox();
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 128'(busy), 128'(0));
      checkOutput("reset_valid", 128'(rk_valid), 128'(0));
      checkOutput("reset_rk", rk, 128'(0));
      checkOutput("reset_round", 128'(rk_round), 128'(0));
      checkOutput("reset_last", 128'(rk_last), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] FIPS-197 key, full throughput");
      applyStimulus(FIPS_KEY);
      runSchedule(1'b0, -1, -1, '0, -1, 1'b1);
      checkOutput("fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      checkOutput("fips_r9", got[9], 128'hac7766f319fadc2128d12941575c006e);
      checkOutput("fips_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
      checkOutput("fips_r0", got[0], FIPS_KEY);
      for (int i = 0; i < 11; i++) gotRef[i] = got[i];

      $display("[TB] back-to-back all-zero key");
      applyStimulus(128'h0);
      runSchedule(1'b0, -1, -1, '0, -1, 1'b1);
      checkOutput("zero_r10", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      checkOutput("zero_r0", got[0], 128'h0);

      $display("[TB] back-to-back FIPS key, rcon restart");
      applyStimulus(FIPS_KEY);
      runSchedule(1'b0, -1, -1, '0, -1, 1'b1);
      checkOutput("b2b_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);

      $display("[TB] random backpressure");
      @(negedge clk);
      applyStimulus(FIPS_KEY);
      runSchedule(1'b1, -1, -1, '0, -1, 1'b0);
      for (int i = 0; i < 11; i++) checkOutput($sformatf("stalled_vs_ref_r%0d", i), got[i], gotRef[i]);

      $display("[TB] start pulsed during EXPAND and EMIT");
      randKey = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      applyStimulus(randKey);
      runSchedule(1'b0, 4, 13, ~randKey, -1, 1'b1);
      checkOutput("inject_r0", got[0], randKey);

      $display("[TB] reset at round 5");
      @(negedge clk);
      applyStimulus(FIPS_KEY);
      runSchedule(1'b0, -1, -1, '0, 5, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      sawValid = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (rk_valid || busy) sawValid = 1'b1;
      end
      checkOutput("no_residual", 128'(sawValid), 128'(0));
      randKey = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(randKey);
      runSchedule(1'b1, -1, -1, '0, -1, 1'b0);
      checkOutput("post_reset_r0", got[0], randKey);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
